lsu_data_mem: RTL and testbench
===============================

Name: lsu_data_mem

Overview:
- Data-memory responder on the far end of the LSU store/load interface.
- Accepts byte, half and word stores from LSU execute; performs them into a little-endian byte-laned word array.
- Serves loads with a registered one-cycle latency, so rd_data is valid when the issuing load reaches LSU writeback.
- Sits between the LSU execute stage and the data RAM array. Flags misaligned, out-of-range and illegal-size accesses in a sticky error register.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, ≥4).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- stall  input  1  hazard-unit stall; same signal that freezes the LSU pipeline registers.
- wr_addr  input  32  store byte address.
- wr_data  input  32  store data; bytes taken from the low end.
- wr_en  input  1  store request.
- wr_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- rd_addr  input  32  load byte address.
- rd_en  input  1  load request.
- rd_size  input  2  encoding as wr_size.
- rd_zero_ext  input  1  1 zero-extend, 0 sign-extend sub-word loads.
- rd_data  output  32  registered load result, right-aligned and extended.
- err  output  1  sticky access-fault flag.
- err_addr  output  32  byte address of the first fault since the last clear.
- err_clr  input  1  clears err and err_addr.

Behaviour:
- Reset (rst=0, asynchronous): rd_data=0, err=0, err_addr=0. Array contents are not cleared.
- Address decode: off = addr − BASE_ADDR, computed modulo 2^32. Word index = off[31:2]; lane = off[1:0].
- Out of range: word index ≥ DEPTH_WORDS.
- Misaligned: half with lane[0]=1, or word with lane≠0.
- Fault: out of range, misaligned, or size=11.
- Store (wr_en=1, stall=0, no fault):
  - Byte: writes lane byte.
  - Half: writes bytes lane and lane+1.
  - Word: writes all 4 bytes.
  - Source data is always wr_data[7:0], [15:0] or [31:0]. Untouched lanes keep their value.
- Faulting store: array unchanged.
- Load (rd_en=1, stall=0): at the edge, rd_data is loaded with the selected bytes shifted to bit 0.
  - Sub-word results are zero- or sign-extended per rd_zero_ext; word loads ignore rd_zero_ext.
  - A faulting load returns rd_data=0.
  - Latency is exactly 1 cycle; rd_data holds until the next accepted load.
- rd_en=0 or stall=1: rd_data holds its value.
- stall=1: stores are suppressed. The same store is re-presented when the stall releases, so no double-write side effects.
- Simultaneous load and store in one cycle (same or different word): both are performed. The load returns pre-store data (read-before-write).
- Error register:
  - Any accepted faulting access (stall=0) sets err.
  - err_addr captures the faulting address only when err was 0; a store fault takes priority over a load fault in the same cycle.
  - err_clr=1 clears both at the edge. If a new fault arrives the same cycle, the fault wins: err=1 and err_addr = the new address.
- No handshake or backpressure toward the LSU; every non-stalled request completes in one cycle.

Test Plan:
- Reset then word store 0x11223344 at 0x10, load word 0x10 next cycle → rd_data=0x11223344 one cycle after rd_en, err=0.
- Byte store 0xAA at 0x13, then load byte 0x13 sign-extended → 0xFFFFFFAA; zero-extended → 0x000000AA; word load 0x10 → 0xAA223344.
- Half store 0xBEEF at 0x22, half load 0x22 signed → 0xFFFFBEEF. Half load at 0x21 → rd_data=0, err=1, err_addr=0x21; a later fault at 0x40 leaves err_addr=0x21.
- Store 0x5 at word 0x30 and load 0x30 in the same cycle with old value 0x9 → rd_data=0x9; next load returns 0x5.
- stall=1 for 2 cycles with a load of 0x10 and a store of 0x0 to 0x10 held → rd_data unchanged and array unchanged during stall. Both complete in the first cycle after release.
- Store to byte address DEPTH_WORDS*4 → array unchanged, err=1. Assert rst=0 mid-cycle → rd_data=0 and err=0 immediately, while previously stored words are still readable.

Source files
------------

// File: rtl/lsu_data_mem.sv
// Data-memory responder for the LSU: byte-laned little-endian word array with
// one-cycle registered loads and a sticky access-fault register.
module lsu_data_mem #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   input  logic        wr_en,
   input  logic [1:0]  wr_size,
   input  logic [31:0] rd_addr,
   input  logic        rd_en,
   input  logic [1:0]  rd_size,
   input  logic        rd_zero_ext,
   output logic [31:0] rd_data,
   output logic        err,
   output logic [31:0] err_addr,
   input  logic        err_clr
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [31:0]   rd_data_q, rd_data_d;
   logic          err_q, err_d;
   logic [31:0]   err_addr_q, err_addr_d;

   logic [31:0]   wr_off, rd_off;
   logic [AW-1:0] wr_widx, rd_widx;
   logic          wr_fault, rd_fault;
   logic          wr_acc, rd_acc;
   logic [3:0]    wr_mask;
   logic [31:0]   wr_lanes;
   logic [31:0]   rd_word, rd_shift, rd_ext;

   // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land out of range.
   assign wr_off  = wr_addr - BASE_ADDR;
   assign rd_off  = rd_addr - BASE_ADDR;
   assign wr_widx = wr_off[AW+1:2];
   assign rd_widx = rd_off[AW+1:2];

   assign wr_fault = (|wr_off[31:AW+2]) || (wr_size == 2'b11)
                  || (wr_size == 2'b01 && wr_off[0])
                  || (wr_size == 2'b10 && wr_off[1:0] != 2'b00);
   assign rd_fault = (|rd_off[31:AW+2]) || (rd_size == 2'b11)
                  || (rd_size == 2'b01 && rd_off[0])
                  || (rd_size == 2'b10 && rd_off[1:0] != 2'b00);

   assign wr_acc = wr_en && !stall;
   assign rd_acc = rd_en && !stall;

   always_comb begin
      wr_mask  = '0;
      wr_lanes = wr_data;
      case (wr_size)
         2'b00: begin
            wr_mask  = 4'b0001 << wr_off[1:0];
            wr_lanes = {4{wr_data[7:0]}};
         end
         2'b01: begin
            wr_mask  = 4'b0011 << wr_off[1:0];
            wr_lanes = {2{wr_data[15:0]}};
         end
         2'b10:   wr_mask = 4'b1111;
         default: wr_mask = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_acc && !wr_fault) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (wr_mask[b]) mem_q[wr_widx][b*8 +: 8] <= wr_lanes[b*8 +: 8];
         end
      end
   end

   assign rd_word  = mem_q[rd_widx];
   assign rd_shift = rd_word >> {rd_off[1:0], 3'b000};

   always_comb begin
      rd_ext = rd_shift;
      case (rd_size)
         2'b00:   rd_ext = {{24{!rd_zero_ext && rd_shift[7]}},  rd_shift[7:0]};
         2'b01:   rd_ext = {{16{!rd_zero_ext && rd_shift[15]}}, rd_shift[15:0]};
         default: rd_ext = rd_shift;
      endcase
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_acc) rd_data_d = rd_fault ? '0 : rd_ext;
   end

   // A same-cycle clear lets a new fault re-capture its address.
   always_comb begin
      err_d      = err_q;
      err_addr_d = err_addr_q;
      if (err_clr) begin
         err_d      = 1'b0;
         err_addr_d = '0;
      end
      if ((wr_acc && wr_fault) || (rd_acc && rd_fault)) begin
         err_d = 1'b1;
         if (!err_q || err_clr) err_addr_d = (wr_acc && wr_fault) ? wr_addr : rd_addr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q  <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         rd_data_q  <= rd_data_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign err      = err_q;
   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Directed bench for lsu_data_mem: stores, extended loads, faults, stall and reset.
module tb_lsu_data_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [31:0] wr_addr, wr_data, rd_addr;
   logic        wr_en, rd_en, rd_zero_ext, err_clr;
   logic [1:0]  wr_size, rd_size;
   logic [31:0] rd_data, err_addr;
   logic        err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lsu_data_mem #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_size(wr_size),
      .rd_addr(rd_addr), .rd_en(rd_en), .rd_size(rd_size), .rd_zero_ext(rd_zero_ext),
      .rd_data(rd_data), .err(err), .err_addr(err_addr), .err_clr(err_clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; wr_en = 0; rd_en = 0; err_clr = 0;
      wr_addr = '0; wr_data = '0; wr_size = 2'b10;
      rd_addr = '0; rd_size = 2'b10; rd_zero_ext = 0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      wr_en = 1; wr_addr = a; wr_data = d; wr_size = s;
      tick();
      wr_en = 0;
   endtask

   task automatic load(input logic [31:0] a, input logic [1:0] s, input logic z);
      rd_en = 1; rd_addr = a; rd_size = s; rd_zero_ext = z;
      tick();
      rd_en = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 0;
      #12;
      tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data got=%h exp=%h", rd_data, 32'h0); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
      tests++; if (err_addr !== 32'h0) begin fails++; $display("FAIL reset_err_addr got=%h exp=0", err_addr); end
      @(negedge clk);
      rst = 1;
      tick();
   endtask

   task automatic test_word();
      store(32'h10, 32'h1122_3344, 2'b10);
      load(32'h10, 2'b10, 0);
      tests++; if (rd_data !== 32'h1122_3344) begin fails++; $display("FAIL word_load got=%h exp=%h", rd_data, 32'h1122_3344); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL word_err got=%b exp=0", err); end
   endtask

   task automatic test_byte();
      store(32'h13, 32'h0000_00AA, 2'b00);
      load(32'h13, 2'b00, 0);
      tests++; if (rd_data !== 32'hFFFF_FFAA) begin fails++; $display("FAIL byte_sext got=%h exp=%h", rd_data, 32'hFFFF_FFAA); end
      load(32'h13, 2'b00, 1);
      tests++; if (rd_data !== 32'h0000_00AA) begin fails++; $display("FAIL byte_zext got=%h exp=%h", rd_data, 32'h0000_00AA); end
      load(32'h10, 2'b10, 1);
      tests++; if (rd_data !== 32'hAA22_3344) begin fails++; $display("FAIL byte_word got=%h exp=%h", rd_data, 32'hAA22_3344); end
      load(32'h11, 2'b00, 0);
      tests++; if (rd_data !== 32'h0000_0033) begin fails++; $display("FAIL byte_lane1 got=%h exp=%h", rd_data, 32'h0000_0033); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL byte_err got=%b exp=0", err); end
   endtask

   task automatic test_half_fault();
      store(32'h22, 32'h1234_BEEF, 2'b01);
      load(32'h22, 2'b01, 0);
      tests++; if (rd_data !== 32'hFFFF_BEEF) begin fails++; $display("FAIL half_sext got=%h exp=%h", rd_data, 32'hFFFF_BEEF); end
      load(32'h22, 2'b01, 1);
      tests++; if (rd_data !== 32'h0000_BEEF) begin fails++; $display("FAIL half_zext got=%h exp=%h", rd_data, 32'h0000_BEEF); end
      load(32'h21, 2'b01, 0);
      tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL half_mis_rd got=%h exp=0", rd_data); end
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL half_mis_err got=%b exp=1", err); end
      tests++; if (err_addr !== 32'h21) begin fails++; $display("FAIL half_mis_addr got=%h exp=%h", err_addr, 32'h21); end
      store(32'h40, 32'h0, 2'b11);
      tests++; if (err_addr !== 32'h21) begin fails++; $display("FAIL sticky_addr got=%h exp=%h", err_addr, 32'h21); end
      err_clr = 1;
      load(32'h42, 2'b10, 0);
      err_clr = 0;
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL clr_fault_err got=%b exp=1", err); end
      tests++; if (err_addr !== 32'h42) begin fails++; $display("FAIL clr_fault_addr got=%h exp=%h", err_addr, 32'h42); end
      err_clr = 1;
      tick();
      err_clr = 0;
      tests++; if (err !== 1'b0 || err_addr !== 32'h0) begin fails++; $display("FAIL clr got=%b/%h exp=0/0", err, err_addr); end
   endtask

   task automatic test_rbw();
      store(32'h30, 32'h9, 2'b10);
      wr_en = 1; wr_addr = 32'h30; wr_data = 32'h5; wr_size = 2'b10;
      load(32'h30, 2'b10, 0);
      wr_en = 0;
      tests++; if (rd_data !== 32'h9) begin fails++; $display("FAIL rbw_old got=%h exp=%h", rd_data, 32'h9); end
      load(32'h30, 2'b10, 0);
      tests++; if (rd_data !== 32'h5) begin fails++; $display("FAIL rbw_new got=%h exp=%h", rd_data, 32'h5); end
   endtask

   task automatic test_stall();
      stall = 1;
      wr_en = 1; wr_addr = 32'h10; wr_data = 32'h0; wr_size = 2'b10;
      rd_en = 1; rd_addr = 32'h10; rd_size = 2'b10;
      for (int i = 0; i < 2; i++) begin
         tick();
         tests++; if (rd_data !== 32'h5) begin fails++; $display("FAIL stall_hold%0d got=%h exp=%h", i, rd_data, 32'h5); end
      end
      stall = 0;
      tick();
      wr_en = 0; rd_en = 0;
      tests++; if (rd_data !== 32'hAA22_3344) begin fails++; $display("FAIL stall_release got=%h exp=%h", rd_data, 32'hAA22_3344); end
      load(32'h10, 2'b10, 0);
      tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL stall_store got=%h exp=0", rd_data); end
   endtask

   task automatic test_range_reset();
      store(32'h0, 32'h1234_5678, 2'b10);
      store(32'h100, 32'hDEAD_BEEF, 2'b10);
      tests++; if (err !== 1'b1 || err_addr !== 32'h100) begin fails++; $display("FAIL oor_err got=%b/%h exp=1/%h", err, err_addr, 32'h100); end
      load(32'h0, 2'b10, 0);
      tests++; if (rd_data !== 32'h1234_5678) begin fails++; $display("FAIL oor_unchanged got=%h exp=%h", rd_data, 32'h1234_5678); end
      #3;
      rst = 0;
      #1;
      tests++; if (rd_data !== 32'h0 || err !== 1'b0) begin fails++; $display("FAIL async_reset got=%h/%b exp=0/0", rd_data, err); end
      #1;
      rst = 1;
      load(32'h0, 2'b10, 0);
      tests++; if (rd_data !== 32'h1234_5678) begin fails++; $display("FAIL reset_keeps_mem got=%h exp=%h", rd_data, 32'h1234_5678); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half_fault();
      test_rbw();
      test_stall();
      test_range_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
